mult_cell_pipe: RTL and testbench
=================================

Name: mult_cell_pipe

Overview:
- Parametrised, pipelined integer multiply cell for the soft-CPU execute/memory path.
- Next generation of the three-partial-product cell. It forms all four half-width partial products and adds the following:
  - the full 2*DATA_W product;
  - signed/unsigned mode selection;
  - a valid/stall/flush pipeline;
  - configurable latency.
- It returns either the low or the high DATA_W bits of the product, as selected per operation.

Parameters:
- DATA_W, 32: operand/result width; must be even, range 8..64.
- LATENCY, 2: cycles from input acceptance to result; range 2..4.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: pipeline advance enable; 0 stalls every stage.
- flush, input, 1: synchronous kill of all in-flight operations.
- in_valid, input, 1: operands/op present this cycle.
- in_op, input, 2: 00 MUL (low half); 01 MULXUU; 10 MULXSU (src1 signed, src2 unsigned); 11 MULXSS.
- src1, input, DATA_W: multiplicand.
- src2, input, DATA_W: multiplier.
- out_valid, output, 1: out_result holds a completed operation.
- out_result, output, DATA_W: selected product half.
- busy, output, 1: OR of all stage valid bits, including the output stage.

Behaviour:
- Priority: reset > flush > en.
- Reset:
  - all stage valid bits, out_valid and busy go to 0;
  - out_result and all partial-product/data registers go to 0.
- Input acceptance: an operation is accepted on an edge where in_valid=1, en=1, flush=0 and reset=0.
  - in_valid with en=0 is not accepted, and the cell does not hold it internally. The upstream must keep presenting it until en=1.
- Stage 1 (registered):
  - Split each operand into lo (unsigned, H=DATA_W/2 bits) and hi (H+1 bits).
  - hi is sign-extended if that operand is signed under in_op, otherwise zero-extended.
  - Register pp_ll=lo1*lo2, pp_lh=lo1*hi2, pp_hl=hi1*lo2, pp_hh=hi1*hi2, each as a signed 2*DATA_W value.
  - Register the op and the valid bit alongside.
- Stage 2:
  - product = pp_ll + ((pp_lh+pp_hl)<<H) + (pp_hh<<DATA_W), evaluated modulo 2^(2*DATA_W).
  - result = product[DATA_W-1:0] for op 00, else product[2*DATA_W-1:DATA_W].
- Stages 3..LATENCY: pure delay registers for result and valid.
- out_result/out_valid are the final registers; no combinational path from inputs to outputs.
- Latency: with en held at 1, an operation accepted at edge k has out_valid=1 with its result after edge k+LATENCY.
- Throughput: 1 operation per cycle, results in issue order.
- Stall (en=0, flush=0):
  - every register, including out_valid and out_result, holds;
  - a valid output stays asserted for the whole stall.
- Bubbles: a stage whose valid bit is 0 still shifts when en=1. out_valid deasserts when a bubble reaches the output, and out_result holds its last valid value.
- Flush:
  - clears all valid bits (busy=0, out_valid=0 after the edge) regardless of en;
  - the data registers keep their values;
  - an in_valid presented in the same cycle is dropped.
- Reset or flush mid-operation: no partially computed result ever appears with out_valid=1.
- Op 00: the result is identical for any signedness, because the low half is sign-independent.

Test Plan (DATA_W=32, LATENCY=2 unless stated):
- src1=0x00010000, src2=0x00010000:
  - op 00 -> 0x00000000 at edge k+2;
  - op 01 -> 0x00000001.
- src1=src2=0xFFFFFFFF:
  - op 11 -> 0x00000000;
  - op 01 -> 0xFFFFFFFE;
  - op 10 -> 0xFFFFFFFF;
  - op 00 -> 0x00000001.
- src1=src2=0x80000000, op 11 -> 0x40000000. Issue back-to-back with the op 01 case above on consecutive cycles: results appear on consecutive cycles, in order.
- Stall: issue 3 ops, drop en for 3 cycles after the first edge.
  - out_valid/out_result hold during the stall;
  - all 3 results emerge in order once en=1;
  - no duplicates.
- Flush and reset: with 2 ops in flight, assert flush alongside a new in_valid.
  - next cycle: busy=0, out_valid=0, and no result ever emerges for any of the 3;
  - repeat with reset: out_result=0 as well.
- DATA_W=16, LATENCY=4: src1=0xFFFF, src2=0x0002, op 10 -> 0xFFFF at edge k+4; op 01 -> 0x0001.

Source files
------------

// File: rtl/mult_cell_pipe.sv
// Pipelined DATA_W x DATA_W integer multiply cell built from four half-width partial products.
// Returns the low or high product half, with signed/unsigned modes, stall (en) and flush.
module mult_cell_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    logic              w_s1_signed;
    logic              w_s2_signed;
    logic [H:0]        w_hi1;
    logic [H:0]        w_hi2;
    logic [PW-1:0]     w_lo1_x;
    logic [PW-1:0]     w_lo2_x;
    logic [PW-1:0]     w_hi1_x;
    logic [PW-1:0]     w_hi2_x;
    logic [PW-1:0]     w_product;
    logic [DATA_W-1:0] w_result;

    logic              r_v1;
    op_e               r_op;
    logic [PW-1:0]     r_pp_ll;
    logic [PW-1:0]     r_pp_lh;
    logic [PW-1:0]     r_pp_hl;
    logic [PW-1:0]     r_pp_hh;
    logic [LATENCY-1:0] r_vld;
    logic [DATA_W-1:0] r_res [LATENCY];

    // Operand split: lo halves are unsigned, hi halves carry the operand's sign as an extra bit.
    always_comb begin
        w_s1_signed = (op_e'(in_op) == OP_MULXSU) || (op_e'(in_op) == OP_MULXSS);
        w_s2_signed = (op_e'(in_op) == OP_MULXSS);
        w_hi1   = {w_s1_signed & src1[DATA_W-1], src1[DATA_W-1:H]};
        w_hi2   = {w_s2_signed & src2[DATA_W-1], src2[DATA_W-1:H]};
        w_lo1_x = {{(PW-H){1'b0}}, src1[H-1:0]};
        w_lo2_x = {{(PW-H){1'b0}}, src2[H-1:0]};
        w_hi1_x = {{(PW-H-1){w_hi1[H]}}, w_hi1};
        w_hi2_x = {{(PW-H-1){w_hi2[H]}}, w_hi2};
    end

    always_comb begin
        w_product = r_pp_ll + ((r_pp_lh + r_pp_hl) << H) + (r_pp_hh << DATA_W);
        w_result  = (r_op == OP_MUL) ? w_product[DATA_W-1:0] : w_product[PW-1:DATA_W];
    end

    // r_res[0] is the stage-2 result; the last slot is the output register and only
    // loads on valid data so out_result keeps its last result across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_op    <= OP_MUL;
            r_pp_ll <= '0;
            r_pp_lh <= '0;
            r_pp_hl <= '0;
            r_pp_hh <= '0;
            r_vld   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_res[i] <= '0;
            end
        end else if (flush) begin
            r_v1  <= 1'b0;
            r_vld <= '0;
        end else if (en) begin
            r_v1     <= in_valid;
            r_op     <= op_e'(in_op);
            r_pp_ll  <= w_lo1_x * w_lo2_x;
            r_pp_lh  <= w_lo1_x * w_hi2_x;
            r_pp_hl  <= w_hi1_x * w_lo2_x;
            r_pp_hh  <= w_hi1_x * w_hi2_x;
            r_vld    <= {r_vld[LATENCY-2:0], r_v1};
            r_res[0] <= w_result;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                if ((i < LATENCY - 1) || r_vld[i-1]) begin
                    r_res[i] <= r_res[i-1];
                end
            end
        end
    end

    assign out_valid  = r_vld[LATENCY-1];
    assign out_result = r_res[LATENCY-1];
    assign busy       = r_v1 | (|r_vld);

endmodule

// File: tb/tb_mult_cell_pipe.sv
// Randomised self-checking bench for mult_cell_pipe (32/2 and 16/4 instances in parallel).
// An arithmetic reference plus an in-flight countdown list predicts outputs every cycle.
module tb_mult_cell_pipe;

    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid;
    logic [1:0]  in_op;
    logic [31:0] src1, src2;

    logic        a_out_valid, a_busy;
    logic [31:0] a_out_result;
    logic        b_out_valid, b_busy;
    logic [15:0] b_out_result;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: per DUT, in-order list of (edges remaining, expected result).
    int          m_lat [2];
    int          m_cnt [2][16];
    logic [63:0] m_res [2][16];
    int          m_n   [2];
    logic        m_ov  [2];
    logic [63:0] m_or  [2];

    always #5 clk = ~clk;

    mult_cell_pipe #(.DATA_W(32), .LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .src1(src1), .src2(src2),
        .out_valid(a_out_valid), .out_result(a_out_result), .busy(a_busy)
    );

    mult_cell_pipe #(.DATA_W(16), .LATENCY(4)) u_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .src1(src1[15:0]), .src2(src2[15:0]),
        .out_valid(b_out_valid), .out_result(b_out_result), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Full-precision product of w-bit operands, then select low or high half.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, ea, eb, p, r;
        mask = (128'd1 << w) - 128'd1;
        ea = {64'd0, a} & mask;
        eb = {64'd0, b} & mask;
        if ((op == 2'b10 || op == 2'b11) && ea[w-1]) ea = ea | ~mask;
        if (op == 2'b11 && eb[w-1]) eb = eb | ~mask;
        p = ea * eb;
        r = (op == 2'b00) ? (p & mask) : ((p >> w) & mask);
        return r[63:0];
    endfunction

    task automatic model_step(input logic r, input logic f, input logic e, input logic v,
                              input logic [63:0] ea, input logic [63:0] eb);
        for (int id = 0; id < 2; id++) begin
            if (r) begin
                m_n[id] = 0; m_ov[id] = 1'b0; m_or[id] = '0;
            end else if (f) begin
                m_n[id] = 0; m_ov[id] = 1'b0;
            end else if (e) begin
                for (int j = 0; j < m_n[id]; j++) m_cnt[id][j]--;
                if (m_n[id] > 0 && m_cnt[id][0] == 0) begin
                    m_ov[id] = 1'b1;
                    m_or[id] = m_res[id][0];
                    for (int j = 1; j < m_n[id]; j++) begin
                        m_cnt[id][j-1] = m_cnt[id][j];
                        m_res[id][j-1] = m_res[id][j];
                    end
                    m_n[id]--;
                end else begin
                    m_ov[id] = 1'b0;
                end
                if (v) begin
                    m_cnt[id][m_n[id]] = m_lat[id];
                    m_res[id][m_n[id]] = (id == 0) ? ea : eb;
                    m_n[id]++;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic e, input logic v,
                       input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ea, input logic [63:0] eb);
        reset = r; flush = f; en = e; in_valid = v; in_op = op; src1 = a; src2 = b;
        @(posedge clk);
        model_step(r, f, e, v, ea, eb);
        #1;
        check("A.out_valid",  {63'd0, a_out_valid}, {63'd0, m_ov[0]});
        check("A.out_result", {32'd0, a_out_result}, m_or[0]);
        check("A.busy",       {63'd0, a_busy}, {63'd0, (m_n[0] != 0) || m_ov[0]});
        check("B.out_valid",  {63'd0, b_out_valid}, {63'd0, m_ov[1]});
        check("B.out_result", {48'd0, b_out_result}, m_or[1]);
        check("B.busy",       {63'd0, b_busy}, {63'd0, (m_n[1] != 0) || m_ov[1]});
    endtask

    // Issue with computed expectations for both instances.
    task automatic iss(input logic e, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        cyc(1'b0, 1'b0, e, v, op, a, b, ref_mul(32, op, {32'd0, a}, {32'd0, b}),
            ref_mul(16, op, {48'd0, a[15:0]}, {48'd0, b[15:0]}));
    endtask

    // Issue with a fixed expected value for the 32-bit instance.
    task automatic iss_a(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] ea);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, op, a, b, ea,
            ref_mul(16, op, {48'd0, a[15:0]}, {48'd0, b[15:0]}));
    endtask

    task automatic iss_b(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] eb);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, op, a, b, ref_mul(32, op, {32'd0, a}, {32'd0, b}), eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) iss(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0000_8000 | ($urandom_range(0, 1) ? 32'hFFFF_0000 : 32'h0);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_lat[0] = 2; m_lat[1] = 4;
        m_n[0] = 0; m_n[1] = 0;
        m_ov[0] = 1'b0; m_ov[1] = 1'b0;
        m_or[0] = '0; m_or[1] = '0;
        reset = 1'b1; flush = 1'b0; en = 1'b1; in_valid = 1'b0;
        in_op = 2'b00; src1 = '0; src2 = '0;

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, 64'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 64'd0);

        // Directed products, back-to-back.
        iss_a(2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0000);
        iss_a(2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001);
        iss_a(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000);
        iss_a(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF);
        iss_a(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001);
        iss_a(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE);
        iss_a(2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000);
        idle(2);
        iss_b(2'b10, 32'h0000_FFFF, 32'h0000_0002, 64'hFFFF);
        iss_b(2'b01, 32'h0000_FFFF, 32'h0000_0002, 64'h0001);
        idle(6);

        // Stall with a valid result at the output and ops still in flight.
        iss(1'b1, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0000_0003);
        iss(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'h0000_0007);
        iss(1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) iss(1'b0, 1'b1, 2'b00, 32'h0000_0005, 32'h0000_0009);
        iss(1'b1, 1'b1, 2'b00, 32'h0000_0005, 32'h0000_0009);
        idle(6);

        // Flush with two ops in flight plus a new one presented.
        iss(1'b1, 1'b1, 2'b01, 32'h1111_1111, 32'h2222_2222);
        iss(1'b1, 1'b1, 2'b11, 32'h3333_3333, 32'hCCCC_CCCC);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'h4444_4444, 32'h5555_5555, 64'd0, 64'd0);
        idle(6);

        // Same with reset.
        iss(1'b1, 1'b1, 2'b01, 32'h7777_7777, 32'h8888_8888);
        iss(1'b1, 1'b1, 2'b11, 32'h9999_9999, 32'hAAAA_AAAA);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'hBBBB_BBBB, 32'hDDDD_DDDD, 64'd0, 64'd0);
        idle(6);

        // Randomised traffic with stalls, bubbles, occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          kind;
            op   = 2'($urandom_range(0, 3));
            a    = rnd_operand();
            b    = rnd_operand();
            kind = $urandom_range(0, 99);
            if (kind < 2)
                cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, op, a, b, 64'd0, 64'd0);
            else if (kind < 6)
                cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, a, b,
                    64'd0, 64'd0);
            else
                iss(1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 70), op, a, b);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
